// File: rtl/aemb_iwb_rom.sv
// rtl/aemb_iwb_rom.sv - instruction wishbone fetch responder over sync memory; optional last-hit buffer via AEMB_IWB_LASTHIT_EN
module aemb_iwb_rom #(
    parameter int ISIZ  = 32,
    parameter int MSIZ  = 12,
    parameter int WAITS = 1
) (
    input  logic            nclk,
    input  logic            nrst,
    input  logic [ISIZ-1:0] iwb_adr_i,
    input  logic            iwb_stb_i,
    output logic [31:0]     iwb_dat_o,
    output logic            iwb_ack_o,
    output logic [MSIZ-1:0] mem_adr_o,
    output logic            mem_re_o,
    input  logic [31:0]     mem_dat_i,
    output logic            busy_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_WAIT = 2'd2,
        S_ACK  = 2'd3
    } state_t;

    localparam int          WAIT_LOAD_I = (WAITS > 0) ? WAITS - 1 : 0;
    localparam logic [3:0]  WAIT_LOAD   = WAIT_LOAD_I[3:0];

    state_t            state_q, state_d;
    logic              rd_phase_q, rd_phase_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [MSIZ-1:0]   adr_q, adr_d;
    logic              re_q, re_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [31:0]       dat_q, dat_d;
    logic              ack_q, ack_d;
    logic              busy_q, busy_d;
    logic [MSIZ-1:0]   fetch_adr;

`ifdef AEMB_IWB_LASTHIT_EN
    logic [MSIZ-1:0]   lh_tag_q, lh_tag_d;
    logic [31:0]       lh_data_q, lh_data_d;
    logic              lh_valid_q, lh_valid_d;
`endif

    // Word address of the incoming fetch; upper bits alias, byte-lane bits are ignored.
    assign fetch_adr = iwb_adr_i[MSIZ+1:2];

    logic unused_adr_bits;
    assign unused_adr_bits = ^{iwb_adr_i[ISIZ-1:MSIZ+2], iwb_adr_i[1:0]};

    // Next-state and registered-output computation for the fetch sequencer.
    always_comb begin
        state_d    = state_q;
        rd_phase_d = 1'b0;
        cnt_d      = cnt_q;
        adr_d      = adr_q;
        re_d       = 1'b0;
        rdata_d    = rdata_q;
        dat_d      = dat_q;
        ack_d      = 1'b0;
`ifdef AEMB_IWB_LASTHIT_EN
        lh_tag_d   = lh_tag_q;
        lh_data_d  = lh_data_q;
        lh_valid_d = lh_valid_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (iwb_stb_i) begin
                    adr_d = fetch_adr;
`ifdef AEMB_IWB_LASTHIT_EN
                    if (lh_valid_q && (fetch_adr == lh_tag_q)) begin
                        rdata_d = lh_data_q;
                        state_d = S_ACK;
                    end else begin
                        re_d    = 1'b1;
                        state_d = S_READ;
                    end
`else
                    re_d    = 1'b1;
                    state_d = S_READ;
`endif
                end
            end
            // First READ edge lets the synchronous memory register the address;
            // the second captures the word it produced.
            S_READ: begin
                if (!iwb_stb_i) begin
                    state_d = S_IDLE;
                end else if (!rd_phase_q) begin
                    rd_phase_d = 1'b1;
                end else begin
                    rdata_d = mem_dat_i;
                    if (WAITS == 0) begin
                        state_d = S_ACK;
                    end else begin
                        cnt_d   = WAIT_LOAD;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!iwb_stb_i) begin
                    state_d = S_IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d = S_ACK;
                end else begin
                    cnt_d = 4'(cnt_q - 4'd1);
                end
            end
            S_ACK: begin
                ack_d   = 1'b1;
                dat_d   = rdata_q;
                state_d = S_IDLE;
`ifdef AEMB_IWB_LASTHIT_EN
                lh_tag_d   = adr_q;
                lh_data_d  = rdata_q;
                lh_valid_d = 1'b1;
`endif
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers, falling-edge clocked with asynchronous reset.
    always_ff @(negedge nclk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= S_IDLE;
            rd_phase_q <= 1'b0;
            cnt_q      <= 4'd0;
            adr_q      <= '0;
            re_q       <= 1'b0;
            rdata_q    <= 32'd0;
            dat_q      <= 32'd0;
            ack_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_phase_q <= rd_phase_d;
            cnt_q      <= cnt_d;
            adr_q      <= adr_d;
            re_q       <= re_d;
            rdata_q    <= rdata_d;
            dat_q      <= dat_d;
            ack_q      <= ack_d;
            busy_q     <= busy_d;
        end
    end

`ifdef AEMB_IWB_LASTHIT_EN
    // One-entry buffer of the last acknowledged word; invalid after reset.
    always_ff @(negedge nclk or negedge nrst) begin
        if (!nrst) begin
            lh_tag_q   <= '0;
            lh_data_q  <= 32'd0;
            lh_valid_q <= 1'b0;
        end else begin
            lh_tag_q   <= lh_tag_d;
            lh_data_q  <= lh_data_d;
            lh_valid_q <= lh_valid_d;
        end
    end
`endif

    assign iwb_dat_o = dat_q;
    assign iwb_ack_o = ack_q;
    assign mem_adr_o = adr_q;
    assign mem_re_o  = re_q;
    assign busy_o    = busy_q;

endmodule

// File: tb/tb_aemb_iwb_rom.sv
// tb/tb_aemb_iwb_rom.sv - scoreboard bench for aemb_iwb_rom
module tb_aemb_iwb_rom;

    logic        nclk = 1'b0;
    logic        nrst;
    logic [31:0] adr1, adr0;
    logic        stb1, stb0;
    logic [31:0] dat1, dat0;
    logic        ack1, ack0;
    logic [11:0] madr1, madr0;
    logic        re1, re0;
    logic [31:0] mdat1 = 32'd0;
    logic [31:0] mdat0 = 32'd0;
    logic        busy1, busy0;

    logic [31:0] mem [0:4095];
    int          edge_cnt = 0;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        logic [31:0] data;
        int          edge_n;
    } exp_t;

    exp_t        sb1[$];
    exp_t        sb0[$];
    logic [11:0] re_sb1[$];
    logic [11:0] re_sb0[$];

    always #5 nclk = ~nclk;

    aemb_iwb_rom #(.ISIZ(32), .MSIZ(12), .WAITS(1)) u_dut (
        .nclk(nclk), .nrst(nrst), .iwb_adr_i(adr1), .iwb_stb_i(stb1),
        .iwb_dat_o(dat1), .iwb_ack_o(ack1), .mem_adr_o(madr1), .mem_re_o(re1),
        .mem_dat_i(mdat1), .busy_o(busy1)
    );

    aemb_iwb_rom #(.ISIZ(32), .MSIZ(12), .WAITS(0)) u_dut0 (
        .nclk(nclk), .nrst(nrst), .iwb_adr_i(adr0), .iwb_stb_i(stb0),
        .iwb_dat_o(dat0), .iwb_ack_o(ack0), .mem_adr_o(madr0), .mem_re_o(re0),
        .mem_dat_i(mdat0), .busy_o(busy0)
    );

    // Synchronous memory: registers the address when read-enabled, data valid next edge.
    always @(negedge nclk) begin
        edge_cnt++;
        if (re1) mdat1 <= mem[madr1];
        if (re0) mdat0 <= mem[madr0];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor for the WAITS=1 instance.
    always @(posedge nclk) begin
        exp_t e;
        if (ack1) begin
            if (sb1.size() == 0) begin
                checks++; errors++;
                $display("FAIL ack1_unexpected: got ack data %h expected no ack", dat1);
            end else begin
                e = sb1.pop_front();
                check("ack1_data", dat1, e.data);
                check("ack1_edge", 32'(edge_cnt), 32'(e.edge_n));
            end
        end
        if (re1) begin
            if (re_sb1.size() == 0) begin
                checks++; errors++;
                $display("FAIL re1_unexpected: got mem_re adr %h expected no read", madr1);
            end else begin
                check("re1_adr", 32'(madr1), 32'(re_sb1.pop_front()));
            end
        end
    end

    // Monitor for the WAITS=0 instance.
    always @(posedge nclk) begin
        exp_t e;
        if (ack0) begin
            if (sb0.size() == 0) begin
                checks++; errors++;
                $display("FAIL ack0_unexpected: got ack data %h expected no ack", dat0);
            end else begin
                e = sb0.pop_front();
                check("ack0_data", dat0, e.data);
                check("ack0_edge", 32'(edge_cnt), 32'(e.edge_n));
            end
        end
        if (re0) begin
            if (re_sb0.size() == 0) begin
                checks++; errors++;
                $display("FAIL re0_unexpected: got mem_re adr %h expected no read", madr0);
            end else begin
                check("re0_adr", 32'(madr0), 32'(re_sb0.pop_front()));
            end
        end
    end

    // Called at a rising edge; returns at the rising edge where ack is seen, stb still high.
    task automatic fetch1(input logic [31:0] a, input logic [31:0] d, input int lat, input bit full);
        exp_t e;
        bit   got;
        adr1 = a;
        stb1 = 1'b1;
        e.data   = d;
        e.edge_n = edge_cnt + 1 + lat;
        sb1.push_back(e);
        if (full) re_sb1.push_back(a[13:2]);
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(posedge nclk);
            got = ack1;
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL fetch1_timeout: got no ack for adr %h expected ack", a);
        end
    endtask

    task automatic fetch0(input logic [31:0] a, input logic [31:0] d, input int lat);
        exp_t e;
        bit   got;
        adr0 = a;
        stb0 = 1'b1;
        e.data   = d;
        e.edge_n = edge_cnt + 1 + lat;
        sb0.push_back(e);
        re_sb0.push_back(a[13:2]);
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(posedge nclk);
            got = ack0;
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL fetch0_timeout: got no ack for adr %h expected ack", a);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        nrst = 1'b0;
        stb1 = 1'b0; stb0 = 1'b0;
        adr1 = 32'd0; adr0 = 32'd0;
        for (int i = 0; i < 4096; i++) mem[i] = 32'hC0DE_0000 | 32'(i);
        mem[4] = 32'hB000_0000;

        repeat (2) @(posedge nclk);
        check("rst_ack",  {31'd0, ack1}, 32'd0);
        check("rst_dat",  dat1, 32'd0);
        check("rst_madr", 32'(madr1), 32'd0);
        check("rst_re",   {31'd0, re1}, 32'd0);
        check("rst_busy", {31'd0, busy1}, 32'd0);
        nrst = 1'b1;
        @(posedge nclk);

        // Single fetch: word 4, ack 4 edges after sampling.
        fetch1(32'h0000_0010, 32'hB000_0000, 4, 1'b1);
        stb1 = 1'b0;
        repeat (3) @(posedge nclk);
        check("hold_dat", dat1, 32'hB000_0000);

        // Reset while in WAIT.
        adr1 = 32'h0000_0060;
        stb1 = 1'b1;
        re_sb1.push_back(12'h018);
        repeat (3) @(posedge nclk);
        check("mid_busy", {31'd0, busy1}, 32'd1);
        nrst = 1'b0;
        #1;
        check("mrst_ack",  {31'd0, ack1}, 32'd0);
        check("mrst_dat",  dat1, 32'd0);
        check("mrst_madr", 32'(madr1), 32'd0);
        check("mrst_re",   {31'd0, re1}, 32'd0);
        check("mrst_busy", {31'd0, busy1}, 32'd0);
        stb1 = 1'b0;
        @(posedge nclk);
        nrst = 1'b1;
        repeat (8) @(posedge nclk);
        check("post_rst_busy", {31'd0, busy1}, 32'd0);

        // Back-to-back with stb held: acks 5 edges apart.
        fetch1(32'h0000_0020, 32'hC0DE_0008, 4, 1'b1);
        fetch1(32'h0000_0024, 32'hC0DE_0009, 4, 1'b1);
        stb1 = 1'b0;
        repeat (3) @(posedge nclk);

        // Abort in READ, then a fresh fetch.
        adr1 = 32'h0000_0050;
        stb1 = 1'b1;
        re_sb1.push_back(12'h014);
        @(posedge nclk);
        stb1 = 1'b0;
        repeat (6) @(posedge nclk);
        check("abort_busy", {31'd0, busy1}, 32'd0);
        check("abort_dat", dat1, 32'hC0DE_0009);
        fetch1(32'h0000_0030, 32'hC0DE_000C, 4, 1'b1);
        stb1 = 1'b0;

        // Alias on the WAITS=0 instance.
        fetch0(32'h0000_4008, 32'hC0DE_0002, 3);
        stb0 = 1'b0;
        repeat (2) @(posedge nclk);

        // Repeat fetch of 0x40.
        fetch1(32'h0000_0040, 32'hC0DE_0010, 4, 1'b1);
        stb1 = 1'b0;
        @(posedge nclk);
`ifdef AEMB_IWB_LASTHIT_EN
        fetch1(32'h0000_0040, 32'hC0DE_0010, 1, 1'b0);
`else
        fetch1(32'h0000_0040, 32'hC0DE_0010, 4, 1'b1);
`endif
        stb1 = 1'b0;
        @(posedge nclk);
        nrst = 1'b0;
        @(posedge nclk);
        nrst = 1'b1;
        @(posedge nclk);
        fetch1(32'h0000_0040, 32'hC0DE_0010, 4, 1'b1);
        stb1 = 1'b0;

        repeat (5) @(posedge nclk);
        checks++;
        if (sb1.size() + sb0.size() + re_sb1.size() + re_sb0.size() != 0) begin
            errors++;
            $display("FAIL leftover: got %0d pending expectations expected 0",
                     sb1.size() + sb0.size() + re_sb1.size() + re_sb0.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
